// File: rtl/bcd_controle_if.sv
// Control-side signal bundle between the frequency-meter controller and its digit chain.
// master = controller (bcd_controle); slave = digit chain / pulse source.
interface bcd_controle_if;
    logic sig;
    logic cnt_max_in;
    logic rst_s;
    logic enb;
    logic ld;
    logic ovf;
    logic nova;

    modport master (
        input  sig,
        input  cnt_max_in,
        output rst_s,
        output enb,
        output ld,
        output ovf,
        output nova
    );

    modport slave (
        output sig,
        output cnt_max_in,
        input  rst_s,
        input  enb,
        input  ld,
        input  ovf,
        input  nova
    );
endinterface

// File: rtl/bcd_controle.sv
// Gate/clear/load sequencer for a 3-digit BCD frequency meter; sticky ovf under BCD_CONTROLE_OVF_HOLD_EN.
// sig rise -> enb two ck edges later; no backpressure, edges in CLEAR/LOAD are dropped.
module bcd_controle #(
    parameter int GATE_CYCLES = 1000
) (
    input  logic           ck,
    input  logic           rst,
    bcd_controle_if.master bus
);
    localparam int GW = $clog2(GATE_CYCLES);

    typedef enum logic [1:0] {CLEAR, COUNT, LOAD} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [GW-1:0] gate_cnt;
    logic          gate_last;
    logic          s1, s2, s3;
    logic          sig_edge;
    logic          ovf_pend;
    logic          ovf_q;
    logic          nova_q;
    logic          rst_s_c;
    logic          enb_c;
    logic          ld_c;

    // Flops reset high so a sig already high at reset release is not seen as a rise.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= bus.sig;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sig_edge  = s2 & ~s3;
    assign gate_last = (gate_cnt == GW'(GATE_CYCLES - 1));

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rst_s_c   = 1'b0;
        enb_c     = 1'b0;
        ld_c      = 1'b0;
        case (state)
            CLEAR: begin
                rst_s_c   = 1'b1;
                state_nxt = COUNT;
            end
            COUNT: begin
                enb_c = sig_edge;
                if (gate_last) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                ld_c      = 1'b1;
                state_nxt = CLEAR;
            end
            default: begin
                rst_s_c   = 1'b1;
                state_nxt = CLEAR;
            end
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            gate_cnt <= '0;
        end else if (state == COUNT && !gate_last) begin
            gate_cnt <= gate_cnt + GW'(1);
        end else begin
            gate_cnt <= '0;
        end
    end

    // An edge while the chain is at 999 still counts (chain wraps), so remember it.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            ovf_pend <= 1'b0;
        end else if (state == CLEAR) begin
            ovf_pend <= 1'b0;
        end else if (state == COUNT && sig_edge && bus.cnt_max_in) begin
            ovf_pend <= 1'b1;
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state == LOAD) begin
`ifdef BCD_CONTROLE_OVF_HOLD_EN
            ovf_q <= ovf_q | ovf_pend;
`else
            ovf_q <= ovf_pend;
`endif
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            nova_q <= 1'b0;
        end else begin
            nova_q <= (state == LOAD);
        end
    end

    assign bus.rst_s = rst_s_c;
    assign bus.enb   = enb_c;
    assign bus.ld    = ld_c;
    assign bus.ovf   = ovf_q;
    assign bus.nova  = nova_q;
endmodule

// File: tb/tb_bcd_controle.sv
// Directed bench for bcd_controle with GATE_CYCLES=10 (12-cycle measurement period).
// Per-period masks give sig per cycle and the expected enb per cycle, indexed from the CLEAR cycle.
module tb_bcd_controle;
    localparam int GC = 10;

`ifdef BCD_CONTROLE_OVF_HOLD_EN
    localparam logic HOLD = 1'b1;
`else
    localparam logic HOLD = 1'b0;
`endif

    logic ck  = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    bcd_controle_if bus ();

    bcd_controle #(.GATE_CYCLES(GC)) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    always #5 ck = ~ck;

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Starts in the CLEAR cycle (index 0); index GC+1 is LOAD.
    task automatic run_period(input string tag, input logic [11:0] sig_m, input logic [11:0] enb_m,
                              input logic cm, input logic nova0, input logic ovf_dur, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            bus.sig        = sig_m[i];
            bus.cnt_max_in = cm;
            chk($sformatf("%s_rst_s_c%0d", tag, i), bus.rst_s, (i == 0));
            chk($sformatf("%s_enb_c%0d", tag, i), bus.enb, enb_m[i]);
            chk($sformatf("%s_ld_c%0d", tag, i), bus.ld, (i == GC + 1));
            chk($sformatf("%s_nova_c%0d", tag, i), bus.nova, (i == 0) ? nova0 : 1'b0);
            chk($sformatf("%s_ovf_c%0d", tag, i), bus.ovf, ovf_dur);
            step();
        end
    endtask

    initial begin
        bus.sig        = 1'b0;
        bus.cnt_max_in = 1'b0;
        rst            = 1'b1;
        repeat (3) step();
        chk("reset_rst_s", bus.rst_s, 1'b1);
        chk("reset_enb", bus.enb, 1'b0);
        chk("reset_ld", bus.ld, 1'b0);
        chk("reset_ovf", bus.ovf, 1'b0);
        chk("reset_nova", bus.nova, 1'b0);
        rst = 1'b0;

        // Idle period, then four 1-high/1-low pulses, then one long high level.
        run_period("idle",   12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 12);
        run_period("count4", 12'h0AA, 12'h2A8, 1'b0, 1'b1, 1'b0, 12);
        run_period("level",  12'h07C, 12'h010, 1'b0, 1'b1, 1'b0, 12);

        // Edge lands in LOAD, then an edge lands in the next CLEAR; both lost.
        run_period("dead_ld",  12'h200, 12'h000, 1'b0, 1'b1, 1'b0, 12);
        run_period("dead_clr", 12'h400, 12'h000, 1'b0, 1'b1, 1'b0, 12);
        run_period("post_dead", 12'h000, 12'h000, 1'b0, 1'b1, 1'b0, 12);

        // Overflow, then a quiet period with cnt_max_in still high, then overflow again.
        run_period("ovf_set",   12'h004, 12'h010, 1'b1, 1'b1, 1'b0, 12);
        run_period("ovf_quiet", 12'h000, 12'h000, 1'b1, 1'b1, 1'b1, 12);
        run_period("ovf_again", 12'h004, 12'h010, 1'b1, 1'b1, HOLD, 12);

        // Reset while gate counter is 5, with an edge in that very cycle.
        run_period("pre_rst", 12'h010, 12'h000, 1'b0, 1'b1, 1'b1, 6);
        chk("mid_enb_before", bus.enb, 1'b1);
        chk("mid_ovf_before", bus.ovf, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_s", bus.rst_s, 1'b1);
        chk("mid_enb", bus.enb, 1'b0);
        chk("mid_ld", bus.ld, 1'b0);
        chk("mid_ovf", bus.ovf, 1'b0);
        chk("mid_nova", bus.nova, 1'b0);
        step();
        rst = 1'b0;
        run_period("post_rst", 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 12);

        // sig held high through reset release is not a rise.
        bus.sig = 1'b1;
        rst     = 1'b1;
        step();
        step();
        rst = 1'b0;
        run_period("sig_high", 12'hFFF, 12'h000, 1'b0, 1'b0, 1'b0, 12);
        run_period("sig_rise", 12'hFFC, 12'h010, 1'b0, 1'b1, 1'b0, 12);
        chk("final_nova", bus.nova, 1'b1);
        chk("final_rst_s", bus.rst_s, 1'b1);
        chk("final_ovf", bus.ovf, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
